// File: rtl/regalu_pipe.sv
// Two-stage register-file/ALU pipeline (ID -> EX) with EX->ID forwarding and a host load port.
// Optional macro ZERO_REG_EN: register 0 is hardwired to zero.
module regalu_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  input  logic              WE3,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [2:0]        opcode,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] ALU_result,
  output logic              res_valid,
  output logic              zero_flag
);

  localparam int SH_W = $clog2(DATA_W);
  localparam int NREG = 2 ** ADDR_W;
`ifdef ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                         OP_XOR = 3'd4, OP_SLT = 3'd5, OP_SLL = 3'd6;

  function automatic logic signed [DATA_W-1:0] alu(input logic [2:0] op,
                                                   input logic signed [DATA_W-1:0] a,
                                                   input logic signed [DATA_W-1:0] b);
    logic [SH_W-1:0] sh;
    sh = b[SH_W-1:0];
    case (op)
      OP_ADD:  alu = a + b;
      OP_SUB:  alu = a - b;
      OP_AND:  alu = a & b;
      OP_OR:   alu = a | b;
      OP_XOR:  alu = a ^ b;
      OP_SLT:  alu = (a < b) ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
      OP_SLL:  alu = a << sh;
      default: alu = $signed($unsigned(a) >> sh);
    endcase
  endfunction

  logic [DATA_W-1:0]        rf [NREG];
  logic signed [DATA_W-1:0] opa_p0, opb_p0;
  logic                     fwd1_p0, fwd2_p0;
  logic signed [DATA_W-1:0] ex_a_p1, ex_b_p1, alu_p1;
  logic [2:0]               ex_op_p1;
  logic                     ex_we_p1;
  logic [ADDR_W-1:0]        ex_a3_p1;
  logic                     vld_p1;
  logic                     wb_ok, host_ok;

  // ID stage: regfile read, overridden by the in-flight EX result on a hazard
  assign fwd1_p0 = vld_p1 && ex_we_p1 && (ex_a3_p1 == A1) && !(ZR && (A1 == '0));
  assign fwd2_p0 = vld_p1 && ex_we_p1 && (ex_a3_p1 == A2) && !(ZR && (A2 == '0));
  assign opa_p0  = fwd1_p0 ? alu_p1 : ((ZR && (A1 == '0)) ? '0 : $signed(rf[A1]));
  assign opb_p0  = fwd2_p0 ? alu_p1 : ((ZR && (A2 == '0)) ? '0 : $signed(rf[A2]));

  // EX stage: combinational ALU on latched operands
  assign alu_p1  = alu(ex_op_p1, ex_a_p1, ex_b_p1);
  assign wb_ok   = vld_p1 && ex_we_p1 && !(ZR && (ex_a3_p1 == '0));
  assign host_ok = host_we && !(ZR && (host_addr == '0));

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      ex_a_p1    <= '0;
      ex_b_p1    <= '0;
      ex_op_p1   <= '0;
      ex_we_p1   <= 1'b0;
      ex_a3_p1   <= '0;
      vld_p1     <= 1'b0;
      ALU_result <= '0;
      res_valid  <= 1'b0;
      zero_flag  <= 1'b0;
    end else begin
      // Pipeline writeback is issued last so it wins a same-address clash with the host
      if (host_ok) rf[host_addr] <= host_wdata;
      if (wb_ok)   rf[ex_a3_p1]  <= $unsigned(alu_p1);
      vld_p1 <= in_valid;
      if (in_valid) begin
        ex_a_p1  <= opa_p0;
        ex_b_p1  <= opb_p0;
        ex_op_p1 <= opcode;
        ex_we_p1 <= WE3;
        ex_a3_p1 <= A3;
      end
      res_valid <= vld_p1;
      if (vld_p1) begin
        ALU_result <= $unsigned(alu_p1);
        zero_flag  <= (alu_p1 == '0);
      end
    end
  end

endmodule

// File: tb/tb_regalu_pipe.sv
// Directed self-checking bench for regalu_pipe (honours ZERO_REG_EN when defined).
module tb_regalu_pipe;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              CLK = 1'b0;
  logic              RST, in_valid, WE3, host_we;
  logic [ADDR_W-1:0] A1, A2, A3, host_addr;
  logic [2:0]        opcode;
  logic [DATA_W-1:0] host_wdata, ALU_result;
  logic              res_valid, zero_flag;

  int vectors = 0;
  int fails   = 0;

  regalu_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .WE3(WE3),
    .A1(A1), .A2(A2), .A3(A3), .opcode(opcode),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .ALU_result(ALU_result), .res_valid(res_valid), .zero_flag(zero_flag)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic [2:0] op, input int a1, input int a2, input int a3, input logic we);
    in_valid = 1'b1;
    opcode   = op;
    A1 = ADDR_W'(a1); A2 = ADDR_W'(a2); A3 = ADDR_W'(a3);
    WE3 = we;
  endtask

  task automatic host_wr(input int addr, input logic [DATA_W-1:0] data);
    host_we = 1'b1; host_addr = ADDR_W'(addr); host_wdata = data;
    step();
    host_we = 1'b0;
  endtask

  task automatic op_chk(input string tag, input logic [2:0] op, input int a1, input int a2,
                        input logic [DATA_W-1:0] exp);
    set_op(op, a1, a2, 0, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    chk(tag, ALU_result, exp);
  endtask

  task automatic rd_chk(input string tag, input int r, input logic [DATA_W-1:0] exp);
    op_chk(tag, 3'd3, r, r, exp);
  endtask

  initial begin
    RST = 1'b1; in_valid = 1'b0; WE3 = 1'b0; host_we = 1'b0;
    A1 = '0; A2 = '0; A3 = '0; host_addr = '0; opcode = '0; host_wdata = '0;
    step(); step();
    RST = 1'b0;
    chk("reset_res_valid", {31'd0, res_valid}, 32'd0);
    chk("reset_result", ALU_result, 32'd0);
    chk("reset_zero", {31'd0, zero_flag}, 32'd0);

    // Plain ADD followed by a dependent SUB that needs the forwarded result
    host_wr(1, 32'd5);
    host_wr(2, 32'd3);
    set_op(3'd0, 1, 2, 3, 1'b1);
    step();
    set_op(3'd1, 3, 1, 4, 1'b1);
    step();
    in_valid = 1'b0;
    chk("add_result", ALU_result, 32'd8);
    chk("add_valid", {31'd0, res_valid}, 32'd1);
    chk("add_zero", {31'd0, zero_flag}, 32'd0);
    step();
    chk("fwd_sub_result", ALU_result, 32'd3);
    chk("fwd_sub_valid", {31'd0, res_valid}, 32'd1);
    step();
    chk("idle_valid_drop", {31'd0, res_valid}, 32'd0);
    chk("idle_result_hold", ALU_result, 32'd3);
    rd_chk("r3_written", 3, 32'd8);
    rd_chk("r4_written", 4, 32'd3);

    // Opcode coverage and boundary values
    op_chk("sub_zero", 3'd1, 1, 1, 32'd0);
    chk("sub_zero_flag", {31'd0, zero_flag}, 32'd1);
    host_wr(2, 32'hFFFF_FFFF);
    host_wr(8, 32'd1);
    host_wr(9, 32'd33);
    host_wr(10, 32'h8000_0000);
    host_wr(11, 32'd31);
    op_chk("slt_neg_pos", 3'd5, 2, 1, 32'd1);
    op_chk("slt_pos_neg", 3'd5, 1, 2, 32'd0);
    op_chk("sll_by_33", 3'd6, 8, 9, 32'd2);
    op_chk("srl_by_31", 3'd7, 10, 11, 32'd1);
    op_chk("add_wrap", 3'd0, 2, 1, 32'd4);
    op_chk("and", 3'd2, 1, 2, 32'd5);
    op_chk("xor", 3'd4, 1, 2, 32'hFFFF_FFFA);
    op_chk("or", 3'd3, 1, 3, 32'hD);

    // Writeback vs host write on the same edge: same address, then different address
    set_op(3'd1, 3, 8, 5, 1'b1);
    step();
    in_valid = 1'b0;
    host_wr(5, 32'd9);
    set_op(3'd1, 3, 8, 5, 1'b1);
    step();
    in_valid = 1'b0;
    host_wr(6, 32'h66);
    rd_chk("r5_pipe_wins", 5, 32'd7);
    rd_chk("r6_host_commits", 6, 32'h66);

    // Reset in the middle of a stream of operations
    set_op(3'd0, 1, 1, 12, 1'b1);
    step();
    set_op(3'd0, 1, 3, 13, 1'b1);
    step();
    set_op(3'd0, 3, 3, 14, 1'b1);
    RST = 1'b1;
    step();
    RST = 1'b0; in_valid = 1'b0;
    chk("rst_valid_c1", {31'd0, res_valid}, 32'd0);
    chk("rst_result_clr", ALU_result, 32'd0);
    step();
    chk("rst_valid_c2", {31'd0, res_valid}, 32'd0);
    rd_chk("rst_r12", 12, 32'd0);
    rd_chk("rst_r13", 13, 32'd0);
    rd_chk("rst_r14", 14, 32'd0);
    rd_chk("rst_r1", 1, 32'd0);
    rd_chk("rst_r5", 5, 32'd0);

    // Write to r0 followed by a dependent read of r0
    host_wr(7, 32'd4);
    set_op(3'd0, 7, 7, 0, 1'b1);
    step();
    set_op(3'd0, 0, 0, 15, 1'b0);
    step();
    in_valid = 1'b0;
    step();
`ifdef ZERO_REG_EN
    chk("r0_fwd_read", ALU_result, 32'd0);
    rd_chk("r0_value", 0, 32'd0);
`else
    chk("r0_fwd_read", ALU_result, 32'd16);
    rd_chk("r0_value", 0, 32'd8);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/regalu_pipe.md
Name: regalu_pipe

Overview:
Parametrised two-stage register-file/ALU datapath, successor to the single-cycle register-file + ALU pair.
- Width, register count and ALU operation set are generalised.
- Adds an issue-valid qualifier, a registered result with a valid flag, a zero flag, EX→ID forwarding for back-to-back dependent operations, and a host load port for preloading registers.
- Sits between the instruction-decode test harness and the result checker.

Parameters:
DATA_W, 32, datapath and register width in bits (≥ 8).
ADDR_W, 5, register address width; register count = 2**ADDR_W.

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  synchronous active-high reset
in_valid  in  1  issue qualifier; an operation is accepted every cycle it is high (no backpressure)
WE3  in  1  write result back to register A3
A1  in  ADDR_W  source register 1
A2  in  ADDR_W  source register 2
A3  in  ADDR_W  destination register
opcode  in  3  ALU operation
host_we  in  1  host register write strobe
host_addr  in  ADDR_W  host write address
host_wdata  in  DATA_W  host write data
ALU_result  out  DATA_W  registered result of the completed operation
res_valid  out  1  ALU_result/zero_flag valid this cycle
zero_flag  out  1  ALU_result == 0

Behaviour:
- One clock (CLK); reset is synchronous and active-high (RST).
- Reset, sampled at a CLK edge with RST=1:
  - all registers, EX stage, ALU_result, res_valid and zero_flag cleared to 0;
  - in-flight operations discarded;
  - no writeback or host write occurs on that edge.
- Stage ID, issue cycle N:
  - A1/A2 read combinationally with forwarding;
  - on in_valid=1, operands, opcode, WE3 and A3 latched into the EX register at the end of N, and ex_valid set;
  - in_valid=0 clears ex_valid.
- Stage EX, cycle N+1:
  - ALU evaluates the latched operands combinationally;
  - at the end of N+1: ALU_result ← ALU out, zero_flag ← (ALU out == 0), res_valid ← ex_valid;
  - regfile[A3] ← ALU out if ex_valid & WE3.
- Latency: result visible exactly 2 cycles after issue. Throughput: 1 operation per cycle.
- Forwarding:
  - if ex_valid & ex_WE3 & ex_A3 == A1 (resp. A2), the ID operand is the current EX ALU output instead of the regfile;
  - an operation at N+2 or later reads the written regfile directly;
  - host writes are not forwarded: a same-cycle read of the host address returns the old value.
- Write conflict: pipeline writeback and host write to the same address on the same edge → pipeline value wins. Different addresses → both commit.
- res_valid with in_valid=0 at N drops to 0 at N+2; ALU_result holds its last value while res_valid=0.
- Opcodes (all arithmetic modulo 2**DATA_W, no carry or overflow output):
  - 000 ADD
  - 001 SUB (in1−in2)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT, signed, result 1 or 0
  - 110 SLL in1 by in2[clog2(DATA_W)−1:0]
  - 111 SRL (logical), same shift amount

Optional Feature:
ZERO_REG_EN:
- Defined: register 0 reads 0 at all times, writes to it (pipeline or host) are dropped, and forwarding never applies when the source address is 0.
- Undefined: register 0 is an ordinary register.

Test Plan:
1. Reset, then host writes r1=5, r2=3; issue ADD A1=1 A2=2 A3=3 WE3=1 at N → N+2: ALU_result=8, res_valid=1, zero_flag=0; r3=8.
2. Back-to-back dependency: the ADD above at N, then SUB A1=3 A2=1 A3=4 at N+1 → forwarded: result 3 at N+3; r4=3.
3. SUB r1−r1 → 0 with zero_flag=1; with r1=5, r2=0xFFFFFFFF (−1), SLT r2,r1 → 1, SLT r1,r2 → 0; SLL 1 by 33 → 2; SRL 0x80000000 by 31 → 1.
4. Same-edge pipeline writeback to r5=7 and host write r5=9 → r5 reads 7; a host write to r6 on the same edge → r6 takes the host value.
5. Issue 3 operations, assert RST on the cycle after the second issue → res_valid=0 for 2 cycles, no destination register modified, all registers read 0.
6. With ZERO_REG_EN: ADD A3=0 of 4+4, then ADD A1=0 A2=0 next cycle → result 0, r0 stays 0; without the macro → result 16.
